// File: rtl/cp0_except_pkg.sv
// Shared CP0 constants: excepttype flag positions, register numbers,
// exception codes, Status/Cause field positions and the taken-event type.
package cp0_except_pkg;

    // excepttype_i flag positions
    localparam int unsigned EXC_SYSCALL_BIT = 8;
    localparam int unsigned EXC_INVALID_BIT = 9;
    localparam int unsigned EXC_ERET_BIT    = 12;

    // CP0 register numbers
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // Cause.ExcCode values
    localparam logic [4:0] EXCCODE_INT = 5'd0;
    localparam logic [4:0] EXCCODE_SYS = 5'd8;
    localparam logic [4:0] EXCCODE_RI  = 5'd10;

    // Status fields
    localparam int unsigned STATUS_IE    = 0;
    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned STATUS_IM_LO = 8;
    localparam int unsigned STATUS_IM_HI = 15;

    // Cause fields
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;
    localparam int unsigned CAUSE_SW_LO  = 8;
    localparam int unsigned CAUSE_SW_HI  = 9;
    localparam int unsigned CAUSE_HW_LO  = 10;
    localparam int unsigned CAUSE_HW_HI  = 15;
    localparam int unsigned CAUSE_BD     = 31;

    // Event taken by the MEM-stage instruction this cycle
    typedef enum logic [2:0] {
        EV_NONE,
        EV_INT,
        EV_SYSCALL,
        EV_INVALID,
        EV_ERET
    } event_t;

    // ExcCode recorded for an exception-class event
    function automatic logic [4:0] exc_code(event_t ev);
        case (ev)
            EV_SYSCALL: return EXCCODE_SYS;
            EV_INVALID: return EXCCODE_RI;
            default:    return EXCCODE_INT;
        endcase
    endfunction

endpackage

// File: rtl/cp0_except_timer.sv
// Count/Compare pair with the latched timer interrupt.
module cp0_timer
    import cp0_except_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic count_wr;
    logic compare_wr;

    // Decode mtc0 writes aimed at the timer registers
    always_comb begin
        count_wr   = we && (waddr == REG_COUNT);
        compare_wr = we && (waddr == REG_COMPARE);
    end

    // Free-running counter, reloadable by mtc0
    always_ff @(posedge clk) begin
        if (rst)           count <= '0;
        else if (count_wr) count <= wdata;
        else               count <= count + 32'd1;
    end

    // Compare register
    always_ff @(posedge clk) begin
        if (rst)             compare <= '0;
        else if (compare_wr) compare <= wdata;
    end

    // Sticky timer interrupt; a Compare write clears it and beats a same-cycle match
    always_ff @(posedge clk) begin
        if (rst)                                   timer_int <= 1'b0;
        else if (compare_wr)                       timer_int <= 1'b0;
        else if (count == compare && compare != '0) timer_int <= 1'b1;
    end

endmodule

// File: rtl/cp0_except.sv
// CP0 exception unit: event decode, redirect, Status/Cause/EPC registers.
module cp0_except
    import cp0_except_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [5:0]  int_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_int;
    logic        int_pending;
    logic        taken_exc;
    logic        unused_bits;
    event_t      ev;

    cp0_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .we        (we_i),
        .waddr     (waddr_i),
        .wdata     (wdata_i),
        .count     (count),
        .compare   (compare),
        .timer_int (timer_int)
    );

    // Prioritised event decode; suppressed during reset and for bubbles
    always_comb begin
        int_pending = status[STATUS_IE] && !status[STATUS_EXL] &&
                      ((cause[CAUSE_HW_HI:CAUSE_HW_LO] & status[STATUS_IM_HI:CAUSE_HW_LO]) != '0);
        ev = EV_NONE;
        if (!rst && valid_i) begin
            if (int_pending)                         ev = EV_INT;
            else if (excepttype_i[EXC_SYSCALL_BIT]) ev = EV_SYSCALL;
            else if (excepttype_i[EXC_INVALID_BIT]) ev = EV_INVALID;
            else if (excepttype_i[EXC_ERET_BIT])    ev = EV_ERET;
        end
        taken_exc   = (ev == EV_INT) || (ev == EV_SYSCALL) || (ev == EV_INVALID);
        unused_bits = ^{excepttype_i[31:13], excepttype_i[11:10], excepttype_i[7:0]};
    end

    // Pipeline redirect
    always_comb begin
        flush_o  = 1'b0;
        new_pc_o = '0;
        if (taken_exc) begin
            flush_o  = 1'b1;
            new_pc_o = EXC_VECTOR;
        end else if (ev == EV_ERET) begin
            flush_o  = 1'b1;
            new_pc_o = epc;
        end
    end

    // mfc0 read mux over committed values
    always_comb begin
        case (raddr_i)
            REG_COUNT:   rdata_o = count;
            REG_COMPARE: rdata_o = compare;
            REG_STATUS:  rdata_o = status;
            REG_CAUSE:   rdata_o = cause;
            REG_EPC:     rdata_o = epc;
            default:     rdata_o = '0;
        endcase
    end

    // Status: mtc0 fields first, event's EXL update last so it wins
    always_ff @(posedge clk) begin
        if (rst) begin
            status <= STATUS_RST;
        end else begin
            if (we_i && waddr_i == REG_STATUS) begin
                status[STATUS_IM_HI:STATUS_IM_LO] <= wdata_i[STATUS_IM_HI:STATUS_IM_LO];
                status[STATUS_EXL:STATUS_IE]      <= wdata_i[STATUS_EXL:STATUS_IE];
            end
            if (taken_exc)          status[STATUS_EXL] <= 1'b1;
            else if (ev == EV_ERET) status[STATUS_EXL] <= 1'b0;
        end
    end

    // Cause: hardware pending sampled every cycle, software bits via mtc0, event fields on entry
    always_ff @(posedge clk) begin
        if (rst) begin
            cause <= '0;
        end else begin
            cause[CAUSE_HW_HI:CAUSE_HW_LO] <= {int_i[5] | timer_int, int_i[4:0]};
            if (we_i && waddr_i == REG_CAUSE)
                cause[CAUSE_SW_HI:CAUSE_SW_LO] <= wdata_i[CAUSE_SW_HI:CAUSE_SW_LO];
            if (taken_exc) begin
                cause[CAUSE_EXC_HI:CAUSE_EXC_LO] <= exc_code(ev);
                if (!status[STATUS_EXL]) cause[CAUSE_BD] <= in_delayslot_i;
            end
        end
    end

    // EPC: mtc0 write, overridden by a first-level exception entry
    always_ff @(posedge clk) begin
        if (rst) begin
            epc <= '0;
        end else if (taken_exc && !status[STATUS_EXL]) begin
            epc <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
        end else if (we_i && waddr_i == REG_EPC) begin
            epc <= wdata_i;
        end
    end

    // Register observation ports
    always_comb begin
        status_o    = status;
        cause_o     = cause;
        epc_o       = epc;
        timer_int_o = timer_int;
    end

endmodule

// File: tb/tb_cp0_except.sv
// Self-checking bench for cp0_except: directed table, hand sequences, random vs. model.
module tb_cp0_except;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] excepttype;
    logic [31:0] pc;
    logic        ds;
    logic [5:0]  int_in;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        timer_int;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // reference model state
    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
    logic        m_timer;
    int          m_kind;   // 0 none, 1 exception/interrupt, 2 eret
    logic [4:0]  m_code;

    always #5 clk = ~clk;

    cp0_except #(.EXC_VECTOR(32'h0000_0020), .STATUS_RST(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid),
        .excepttype_i   (excepttype),
        .pc_i           (pc),
        .in_delayslot_i (ds),
        .int_i          (int_in),
        .we_i           (we),
        .waddr_i        (waddr),
        .wdata_i        (wdata),
        .raddr_i        (raddr),
        .rdata_o        (rdata),
        .flush_o        (flush),
        .new_pc_o       (new_pc),
        .status_o       (status),
        .cause_o        (cause),
        .epc_o          (epc),
        .timer_int_o    (timer_int)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; valid = 1'b0; excepttype = '0; pc = '0; ds = 1'b0;
        int_in = '0; we = 1'b0; waddr = '0; wdata = '0;
    endtask

    task automatic model_reset();
        m_count = '0; m_compare = '0; m_status = 32'h0; m_cause = '0; m_epc = '0; m_timer = 1'b0;
    endtask

    // Let inputs settle, predict this cycle's event and compare every output
    task automatic settle();
        logic ip;
        logic [31:0] exp_npc, exp_rd;
        #2;
        ip = m_status[0] && !m_status[1] && (((m_cause >> 10) & (m_status >> 10) & 32'h3F) != 0);
        m_kind = 0; m_code = 0;
        if (!rst && valid) begin
            if (ip)                 begin m_kind = 1; m_code = 5'd0;  end
            else if (excepttype[8]) begin m_kind = 1; m_code = 5'd8;  end
            else if (excepttype[9]) begin m_kind = 1; m_code = 5'd10; end
            else if (excepttype[12]) m_kind = 2;
        end
        exp_npc = (m_kind == 1) ? 32'h20 : (m_kind == 2) ? m_epc : 32'h0;
        case (raddr)
            5'd9:    exp_rd = m_count;
            5'd11:   exp_rd = m_compare;
            5'd12:   exp_rd = m_status;
            5'd13:   exp_rd = m_cause;
            5'd14:   exp_rd = m_epc;
            default: exp_rd = 32'h0;
        endcase
        check("m_flush",  {31'b0, flush}, {31'b0, m_kind != 0});
        check("m_new_pc", new_pc, exp_npc);
        check("m_rdata",  rdata, exp_rd);
        check("m_status", status, m_status);
        check("m_cause",  cause, m_cause);
        check("m_epc",    epc, m_epc);
        check("m_timer",  {31'b0, timer_int}, {31'b0, m_timer});
    endtask

    // Clock edge, then move the model to its next state
    task automatic advance();
        logic [31:0] ns, nc, ne, ncnt, ncmp;
        logic [5:0]  hw;
        logic        nt;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            ns = m_status;
            if (we && waddr == 5'd12) ns = (m_status & ~32'h0000_FF03) | (wdata & 32'h0000_FF03);
            hw = {int_in[5] | m_timer, int_in[4:0]};
            nc = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
            if (we && waddr == 5'd13) nc = (nc & ~32'h0000_0300) | (wdata & 32'h0000_0300);
            ne = (we && waddr == 5'd14) ? wdata : m_epc;
            if (m_kind == 1) begin
                ns = ns | 32'h2;
                nc = (nc & ~32'h7C) | (32'(m_code) << 2);
                if (!m_status[1]) begin
                    ne = ds ? pc - 32'd4 : pc;
                    nc = ds ? (nc | 32'h8000_0000) : (nc & 32'h7FFF_FFFF);
                end
            end else if (m_kind == 2) begin
                ns = ns & ~32'h2;
            end
            ncnt = (we && waddr == 5'd9) ? wdata : m_count + 32'd1;
            ncmp = (we && waddr == 5'd11) ? wdata : m_compare;
            if (we && waddr == 5'd11)                        nt = 1'b0;
            else if (m_count == m_compare && m_compare != 0) nt = 1'b1;
            else                                             nt = m_timer;
            m_status = ns; m_cause = nc; m_epc = ne;
            m_count = ncnt; m_compare = ncmp; m_timer = nt;
        end
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(); we = 1'b1; waddr = a; wdata = d;
        cycle();
        we = 1'b0;
    endtask

    typedef struct {
        logic [31:0] st_init;
        logic [31:0] epc_init;
        logic        vld;
        logic [31:0] exc;
        logic [31:0] pcv;
        logic        dsv;
        logic        exp_flush;
        logic [31:0] exp_npc;
        logic [31:0] exp_epc;
        logic [4:0]  exp_code;
        logic        exp_bd;
        logic        exp_exl;
    } vec_t;

    vec_t tbl[10];

    initial begin
        bit seen;
        logic [31:0] w;
        int sel;

        tbl[0] = '{32'h0,    32'h0,   1'b1, 32'h100,   32'h400, 1'b0, 1'b1, 32'h20,  32'h400, 5'd8,  1'b0, 1'b1};
        tbl[1] = '{32'h0,    32'h0,   1'b1, 32'h200,   32'h508, 1'b1, 1'b1, 32'h20,  32'h504, 5'd10, 1'b1, 1'b1};
        tbl[2] = '{32'h0,    32'h0,   1'b1, 32'h300,   32'h600, 1'b0, 1'b1, 32'h20,  32'h600, 5'd8,  1'b0, 1'b1};
        tbl[3] = '{32'h2,    32'h404, 1'b1, 32'h1000,  32'h410, 1'b0, 1'b1, 32'h404, 32'h404, 5'd0,  1'b0, 1'b0};
        tbl[4] = '{32'h2,    32'h120, 1'b1, 32'h100,   32'h700, 1'b0, 1'b1, 32'h20,  32'h120, 5'd8,  1'b0, 1'b1};
        tbl[5] = '{32'h0,    32'h40,  1'b0, 32'h100,   32'h780, 1'b0, 1'b0, 32'h0,   32'h40,  5'd0,  1'b0, 1'b0};
        tbl[6] = '{32'h0,    32'h44,  1'b1, 32'hE0FF,  32'h790, 1'b0, 1'b0, 32'h0,   32'h44,  5'd0,  1'b0, 1'b0};
        tbl[7] = '{32'h0,    32'h0,   1'b1, 32'h1100,  32'h800, 1'b0, 1'b1, 32'h20,  32'h800, 5'd8,  1'b0, 1'b1};
        tbl[8] = '{32'hFF01, 32'h0,   1'b1, 32'h100,   32'h900, 1'b1, 1'b1, 32'h20,  32'h8FC, 5'd8,  1'b1, 1'b1};
        tbl[9] = '{32'h3,    32'h50,  1'b1, 32'h200,   32'hA08, 1'b1, 1'b1, 32'h20,  32'h50,  5'd10, 1'b0, 1'b1};

        idle(); raddr = 5'd12; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; model_reset();

        // reset state, outputs quiet during reset even with an event presented
        valid = 1'b1; excepttype = 32'h100; pc = 32'h400;
        settle();
        check("rst_flush",  {31'b0, flush}, 32'h0);
        check("rst_new_pc", new_pc, 32'h0);
        check("rst_status", status, 32'h0);
        check("rst_cause",  cause, 32'h0);
        check("rst_epc",    epc, 32'h0);
        check("rst_timer",  {31'b0, timer_int}, 32'h0);
        advance();

        // directed table
        for (int i = 0; i < 10; i++) begin
            idle(); rst = 1'b1; cycle();
            mtc0(5'd12, tbl[i].st_init);
            mtc0(5'd14, tbl[i].epc_init);
            idle();
            valid = tbl[i].vld; excepttype = tbl[i].exc; pc = tbl[i].pcv; ds = tbl[i].dsv;
            settle();
            check($sformatf("t%0d_flush", i), {31'b0, flush}, {31'b0, tbl[i].exp_flush});
            check($sformatf("t%0d_new_pc", i), new_pc, tbl[i].exp_npc);
            advance();
            idle();
            settle();
            check($sformatf("t%0d_epc", i), epc, tbl[i].exp_epc);
            check($sformatf("t%0d_code", i), 32'(cause[6:2]), 32'(tbl[i].exp_code));
            check($sformatf("t%0d_bd", i), {31'b0, cause[31]}, {31'b0, tbl[i].exp_bd});
            check($sformatf("t%0d_exl", i), {31'b0, status[1]}, {31'b0, tbl[i].exp_exl});
            advance();
        end

        // Count wrap
        idle(); rst = 1'b1; cycle();
        mtc0(5'd9, 32'hFFFF_FFFF);
        idle(); raddr = 5'd9;
        settle(); check("wrap_pre", rdata, 32'hFFFF_FFFF); advance();
        settle(); check("wrap_post", rdata, 32'h0); advance();

        // Timer interrupt flow
        idle(); rst = 1'b1; cycle();
        mtc0(5'd11, 32'd5);
        mtc0(5'd12, 32'h8001);
        idle(); raddr = 5'd9;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            settle();
            if (timer_int === 1'b1) begin
                seen = 1;
                check("timer_count", rdata, 32'd6);
            end
            advance();
        end
        check("timer_rise", {31'b0, seen}, 32'h1);
        valid = 1'b1; excepttype = 32'h0; pc = 32'hC00;
        seen = 0;
        for (int k = 0; k < 5 && !seen; k++) begin
            settle();
            if (flush === 1'b1) begin
                seen = 1;
                check("int_new_pc", new_pc, 32'h20);
            end
            advance();
        end
        check("int_taken", {31'b0, seen}, 32'h1);
        idle();
        settle();
        check("int_code", 32'(cause[6:2]), 32'h0);
        check("int_epc",  epc, 32'hC00);
        check("int_exl",  {31'b0, status[1]}, 32'h1);
        advance();
        mtc0(5'd11, 32'd100);
        idle(); settle(); check("timer_clear", {31'b0, timer_int}, 32'h0); advance();
        mtc0(5'd9, 32'd200);
        mtc0(5'd11, 32'd201);
        mtc0(5'd11, 32'd300);
        idle(); settle(); check("timer_clear_wins", {31'b0, timer_int}, 32'h0); advance();

        // Reset while inside a handler
        idle(); rst = 1'b1; cycle();
        idle(); valid = 1'b1; excepttype = 32'h100; pc = 32'h440; cycle();
        idle(); rst = 1'b1; valid = 1'b1; excepttype = 32'h100; pc = 32'h480;
        settle();
        check("midrst_flush", {31'b0, flush}, 32'h0);
        check("midrst_new_pc", new_pc, 32'h0);
        advance();
        idle();
        settle();
        check("midrst_status", status, 32'h0);
        check("midrst_epc",    epc, 32'h0);
        check("midrst_cause",  cause, 32'h0);
        check("midrst_flush2", {31'b0, flush}, 32'h0);
        advance();

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst   = ($urandom_range(0, 199) == 0);
            valid = $urandom_range(0, 1);
            sel = $urandom_range(0, 5);
            case (sel)
                0: excepttype = 32'h0;
                1: excepttype = 32'h100;
                2: excepttype = 32'h200;
                3: excepttype = 32'h300;
                4: excepttype = 32'h1000;
                default: excepttype = $urandom;
            endcase
            pc     = $urandom & 32'hFFFF_FFFC;
            ds     = $urandom_range(0, 1);
            int_in = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
            we     = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 6);
            case (sel)
                0: waddr = 5'd9;
                1: waddr = 5'd11;
                2: waddr = 5'd12;
                3: waddr = 5'd13;
                4: waddr = 5'd14;
                default: waddr = 5'($urandom);
            endcase
            w = $urandom;
            if (waddr == 5'd11 && $urandom_range(0, 1) == 1) w = m_count + $urandom_range(0, 6);
            wdata = w;
            raddr = 5'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
